// File: rtl/booth_mul_sequencer.sv
// Sequencer for a radix-2 Booth multiplier datapath: accepts operand pairs,
// steps the datapath through load/iterate/capture and buffers products in a 2-entry FIFO.
module booth_mul_sequencer #(
    parameter int WIDTH_IN = 16,
    parameter int WIDTH_FP = 32,
    parameter int MAX_RUN  = 40
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH_IN-1:0] in_a,
    input  logic [WIDTH_IN-1:0] in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH_FP-1:0] out_product,
    output logic                busy,
    output logic                err_timeout,
    output logic [WIDTH_IN-1:0] multiplicand_a,
    output logic [WIDTH_IN-1:0] multiplier_b,
    output logic                load,
    output logic                load_pp,
    output logic                load_p,
    output logic                enable_a,
    output logic                enable_b,
    output logic                enable_pp,
    input  logic                count,
    input  logic [WIDTH_FP-1:0] product
);

    localparam int RUN_W = $clog2(MAX_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        WRITE   = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [RUN_W-1:0]   run_cnt_reg, run_cnt_next;

    logic [WIDTH_FP-1:0] fifo_mem [2];
    logic                rd_ptr_reg, rd_ptr_next;
    logic                wr_ptr_reg, wr_ptr_next;
    logic [1:0]          fifo_count_reg, fifo_count_next;
    logic [WIDTH_FP-1:0] head_next;

    logic                in_ready_reg;
    logic [WIDTH_FP-1:0] out_product_reg;
    logic                busy_reg, err_timeout_reg;
    logic [WIDTH_IN-1:0] multiplicand_a_reg, multiplier_b_reg;
    logic                load_reg, load_pp_reg, load_p_reg;
    logic                enable_a_reg, enable_b_reg, enable_pp_reg;

    logic accept, push, pop, timeout;

    assign accept  = (state_reg == IDLE) && in_valid && in_ready_reg;
    assign push    = (state_reg == WRITE);
    assign pop     = out_valid && out_ready;
    assign timeout = (state_reg == RUN) && !count && (run_cnt_reg == RUN_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            run_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            run_cnt_reg <= run_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        run_cnt_next = run_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = LOAD;
            end
            LOAD: begin
                state_next   = RUN;
                run_cnt_next = '0;
            end
            RUN: begin
                run_cnt_next = run_cnt_reg + RUN_W'(1);
                if (count)        state_next = CAPTURE;
                else if (timeout) state_next = IDLE;
            end
            CAPTURE: state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The head register must see a product being pushed into an empty (or just-drained) slot.
    always_comb begin
        rd_ptr_next     = rd_ptr_reg ^ pop;
        wr_ptr_next     = wr_ptr_reg ^ push;
        fifo_count_next = fifo_count_reg;
        if (push && !pop)      fifo_count_next = fifo_count_reg + 2'd1;
        else if (pop && !push) fifo_count_next = fifo_count_reg - 2'd1;
        head_next = (push && (wr_ptr_reg == rd_ptr_next)) ? product : fifo_mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (push && !reset) fifo_mem[wr_ptr_reg] <= product;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg         <= 1'b0;
            wr_ptr_reg         <= 1'b0;
            fifo_count_reg     <= 2'd0;
            out_product_reg    <= '0;
            in_ready_reg       <= 1'b0;
            busy_reg           <= 1'b0;
            err_timeout_reg    <= 1'b0;
            multiplicand_a_reg <= '0;
            multiplier_b_reg   <= '0;
            load_reg           <= 1'b0;
            load_pp_reg        <= 1'b0;
            load_p_reg         <= 1'b0;
            enable_a_reg       <= 1'b0;
            enable_b_reg       <= 1'b0;
            enable_pp_reg      <= 1'b0;
        end else begin
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
            fifo_count_reg <= fifo_count_next;
            if (fifo_count_next != 2'd0) out_product_reg <= head_next;
            if (accept) begin
                multiplicand_a_reg <= in_a;
                multiplier_b_reg   <= in_b;
            end
            if (timeout) err_timeout_reg <= 1'b1;
            in_ready_reg  <= (state_next == IDLE) && (fifo_count_next != 2'd2);
            busy_reg      <= (state_next != IDLE);
            load_reg      <= (state_next == LOAD);
            load_pp_reg   <= (state_next == LOAD);
            load_p_reg    <= (state_next == CAPTURE);
            enable_a_reg  <= (state_next == RUN);
            enable_b_reg  <= (state_next == RUN);
            enable_pp_reg <= (state_next == RUN);
        end
    end

    // Only one operation is ever in flight and accept needs a free slot.
    assert property (@(posedge clk) disable iff (reset) !(push && fifo_count_reg == 2'd2));

    assign in_ready       = in_ready_reg;
    assign out_valid      = (fifo_count_reg != 2'd0);
    assign out_product    = out_product_reg;
    assign busy           = busy_reg;
    assign err_timeout    = err_timeout_reg;
    assign multiplicand_a = multiplicand_a_reg;
    assign multiplier_b   = multiplier_b_reg;
    assign load           = load_reg;
    assign load_pp        = load_pp_reg;
    assign load_p         = load_p_reg;
    assign enable_a       = enable_a_reg;
    assign enable_b       = enable_b_reg;
    assign enable_pp      = enable_pp_reg;

endmodule

// File: doc/booth_mul_sequencer.md
# booth_mul_sequencer

Sequencing and result-buffering stage wrapped around the Booth multiplier datapath. It accepts operand pairs on a valid/ready stream and drives the datapath's operand, load and enable inputs through one radix-2 Booth multiplication. It monitors the datapath's iteration-done flag and captures the finished product into a 2-entry output FIFO presented on a valid/ready stream. It replaces hand-driven load/enable sequencing at the datapath's boundary.

## Interface
- WIDTH_IN, 16, operand width (multiplicand and multiplier, two's complement)
- WIDTH_FP, 32, product width (2*WIDTH_IN)
- MAX_RUN, 40, RUN-state cycle limit before timeout
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- in_a  in  WIDTH_IN  multiplicand
- in_b  in  WIDTH_IN  multiplier
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes FIFO head
- out_product  out  WIDTH_FP  FIFO head product
- busy  out  1  multiplication in flight (state != IDLE)
- err_timeout  out  1  sticky; set on RUN timeout, cleared only by reset
- multiplicand_a, multiplier_b  out  WIDTH_IN  registered operands to the datapath
- load, load_pp, load_p  out  1  datapath load strobes
- enable_a, enable_b, enable_pp  out  1  datapath iteration enables
- count  in  1  datapath done flag (iterations complete)
- product  in  WIDTH_FP  datapath final product

## Operation
- States: IDLE, LOAD, RUN, CAPTURE, WRITE. All strobes/enables are registered Moore outputs decoded from state.
- IDLE: in_ready = (fifo_count < 2). On in_valid && in_ready, register in_a/in_b into multiplicand_a/multiplier_b and go to LOAD. Operands hold until the next accept.
- LOAD (1 cycle): load = load_pp = 1. Go to RUN and clear run_cnt to 0.
- RUN: enable_a = enable_b = enable_pp = 1 and run_cnt increments. On count == 1, go to CAPTURE. Otherwise, if run_cnt == MAX_RUN-1, set err_timeout and go to IDLE without a FIFO write.
- CAPTURE (1 cycle): load_p = 1.
- WRITE (1 cycle): push the product input into the FIFO, then go to IDLE.
- FIFO: 2 entries, with a registered read pointer, write pointer and fifo_count (0..2).
  - out_valid = (fifo_count != 0).
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle leave fifo_count unchanged; the order is preserved.
  - Push while full cannot occur, because accept requires a free slot and only one operation is in flight. An assertion checks this.
- Product is passed through unmodified: WIDTH_FP-bit signed result, no saturation, no rounding.
- Reset: state = IDLE, FIFO emptied (pointers and count 0), run_cnt = 0.
  - All outputs reset to 0: in_ready, out_valid, out_product, busy, err_timeout, operands, strobes, enables.
  - in_ready becomes 1 on the first cycle after reset deasserts.
- Reset mid-operation aborts the multiplication. No partial result is ever pushed.
- in_valid while not ready: operands are not sampled. The upstream must hold them (standard valid/ready).

## Timing
- Accept at edge T0 (cycle 0).
  - Cycle 1: LOAD.
  - Cycles 2..N: RUN, where N is the first cycle count == 1.
  - Cycle N+1: CAPTURE.
  - Cycle N+2: WRITE.
  - Cycle N+3: out_valid high, in_ready high again.
- With the 16-iteration datapath, RUN lasts 17 cycles (cycles 2..18). Latency is 21 cycles from accept to out_valid.
- Throughput is one multiplication per 21 cycles. The FIFO absorbs up to 2 results with out_ready low; a third accept stalls until a pop.
- busy is high from cycle 1 through cycle N+2.
- err_timeout rises the cycle after the MAX_RUN-th RUN cycle. It does not block further accepts.

## Test plan
- Single op: in_a=3, in_b=5 with out_ready=1 -> out_valid 21 cycles after accept, out_product=0x0000000F, one pulse each of load/load_pp/load_p.
- Signed: (-7)*6 and (-32768)*(-32768), back to back -> 0xFFFFFFD6 then 0x40000000, in order.
- Back-pressure: out_ready=0, issue 3 ops (2*2, 3*3, 4*4) -> 2 accepted, in_ready stays 0 after the second result is written. Raise out_ready -> pops 4, then 9, third accepted, then 16.
- Simultaneous push/pop: FIFO holds 1 entry, out_ready=1 in the WRITE cycle -> fifo_count stays 1, correct head order.
- Timeout: model holds count=0 -> err_timeout=1 after 40 RUN cycles, state returns to IDLE, no out_valid. The next op still completes correctly with err_timeout remaining 1.
- Reset mid-RUN (cycle 8 of op 5*5) with 1 entry queued -> next cycle all outputs 0, FIFO empty. New op 6*7 yields 0x0000002A.
